fft_iter_stream: RTL and testbench
==================================

// Module: fft_iter_stream
// PURPOSE
// Iterative in-place radix-2 DIT FFT with streaming sample I/O and valid/ready handshakes.
// Accepts N complex samples serially, runs log2(N) stages at one butterfly per clock
// over an internal N-entry complex buffer, then streams N bins in natural order.
// Area-efficient successor to the fully unrolled DIT FFT: sizes up to 1024 points with one multiplier set.
// PARAMETERS
// N     8    transform points; power of two, 2..1024
// RN    16   sample/result width, two's complement, per real and imaginary part
// FRAC  14   twiddle fraction bits; twiddle = round(2^FRAC * exp(-j*2*pi*k/N)); requires FRAC < RN
// PORTS
// clk        in   1   clock, all state updates on rising edge
// reset      in   1   synchronous reset, active high
// in_valid   in   1   input sample valid
// in_ready   out  1   block accepts a sample this cycle
// in_re      in   RN  input sample, real part
// in_im      in   RN  input sample, imaginary part
// out_valid  out  1   output bin valid
// out_ready  in   1   downstream accepts the bin this cycle
// out_re     out  RN  output bin, real part
// out_im     out  RN  output bin, imaginary part
// out_last   out  1   high with bin N-1
// busy       out  1   high in COMPUTE and UNLOAD
// BEHAVIOUR
// - Reset (sync, active high): state=LOAD, counters=0. in_ready=1 on the cycle after reset.
//   out_valid=0, out_last=0, busy=0, out_re/out_im=0. Buffer contents are not reset.
// - LOAD:
//   - in_ready=1. Transfer = in_valid & in_ready.
//   - The k-th accepted sample (k=0..N-1) is written to buffer[bitrev(k)].
//   - After sample N-1: state=COMPUTE next cycle, in_ready=0.
// - COMPUTE:
//   - Stages s=0..log2(N)-1, butterflies b=0..N/2-1, one per cycle.
//     Span h=2^s. Pair indices: i=(b/h)*2h + b%h, j=i+h. Twiddle index t=(b%h)*N/(2h).
//   - Per butterfly: w = buffer[j] * W[t], as complex multiply.
//     - Full-precision products, real sum/difference, then arithmetic shift right FRAC.
//     - Result truncated to RN bits.
//   - Write buffer[i] = buffer[i] + w and buffer[j] = buffer[i] - w in the same cycle.
//     Both add and subtract wrap modulo 2^RN with no saturation.
//   - Duration is exactly log2(N)*N/2 cycles. in_valid is ignored; no samples are accepted.
//   - N=2 is a single butterfly with t=0.
// - UNLOAD:
//   - out_valid=1. out_re/out_im = buffer[m] for m=0..N-1, natural order.
//   - m advances only when out_valid & out_ready.
//   - With out_ready=0, outputs hold stable and m does not advance.
//   - out_last=1 when m=N-1. After that transfer: state=LOAD, out_valid=0, busy=0 next cycle.
//   - First bin appears the cycle after COMPUTE ends.
// - Minimum frame period (out_ready=1): N + log2(N)*N/2 + N cycles.
// - Twiddle ROM W[0..N/2-1] is generated at elaboration with $cos/$sin and rounding to nearest.
// - Reset has priority over every event, including mid-LOAD, mid-COMPUTE and mid-UNLOAD.
//   The partial frame is discarded and the block returns to LOAD.
// - A reset asserted in the same cycle as an input or output transfer voids that transfer.
// CONFIGURATION
// FFT_STAGE_SCALE_EN
// - Defined: each butterfly output is arithmetically shifted right by 1 before write-back.
//   Overall result = DFT/N; no overflow for any |input| < 2^(RN-1)/sqrt(2).
// - Undefined: unscaled DFT with wrapping overflow, as described above.
// TESTING
// (N=8, RN=16, FRAC=14, macro undefined unless stated)
// 1 Impulse: x[0]=1000, rest 0 -> all 8 bins 1000+0j; out_last only on bin 7.
// 2 DC: all x=1000+0j -> X[0]=8000+0j; X[1..7] within +-1 LSB of 0.
// 3 Tone: x[n]=2048*exp(+j*2*pi*n/8) -> X[1] within +-8 LSB of 16384+0j; other bins |re|,|im|<=8.
// 4 Backpressure: random out_ready (50%) on test 2 -> identical bin sequence, each bin held stable while stalled.
//   in_valid held high throughout COMPUTE -> no sample accepted; in_ready=0 exactly 12 cycles plus UNLOAD.
// 5 Reset at COMPUTE cycle 5 -> next cycle in_ready=1, busy=0, out_valid=0.
//   A following impulse frame then yields correct results.
// 6 FFT_STAGE_SCALE_EN defined, test 2 -> X[0]=1000; test 1 -> all bins 125 (+-1 LSB).

Source files
------------

// File: rtl/fft_iter_stream.sv
// fft_iter_stream: iterative in-place radix-2 DIT FFT with streaming I/O.
//   Samples are loaded serially into bit-reversed buffer positions. log2(N)
//   stages are then run at one butterfly per clock, and the N bins are
//   streamed out in natural order.
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   in_valid/in_ready      input handshake; in_re/in_im carry the sample
//   out_valid/out_ready    output handshake; out_re/out_im carry the bin
//   out_last               high with bin N-1
//   busy                   high while computing or unloading
// Build option: FFT_STAGE_SCALE_EN -- when defined, each butterfly output is
//   halved, so the block produces DFT/N instead of the wrapping unscaled DFT.
module fft_iter_stream #(
  parameter int N    = 8,
  parameter int RN   = 16,
  parameter int FRAC = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [RN-1:0] in_re,
  input  logic signed [RN-1:0] in_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [RN-1:0] out_re,
  output logic signed [RN-1:0] out_im,
  output logic                 out_last,
  output logic                 busy
);
  // state     | meaning
  // S_LOAD    | accepting samples, writing buffer[bitrev(k)]
  // S_COMPUTE | one butterfly per clock, log2(N)*N/2 cycles
  // S_UNLOAD  | streaming buffer[0..N-1] under out_ready

  localparam int L  = $clog2(N);
  localparam int AW = L;
  localparam int TA = (L > 1) ? L - 1 : 1;
  localparam int TW = FRAC + 2;        // holds +/-2^FRAC exactly
  localparam int PW = RN + TW + 1;     // product plus one bit for the sum

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;

  state_t state;
  logic [AW-1:0] cnt;
  logic [AW-1:0] bfly;
  logic [3:0]    stage;

  logic signed [RN-1:0] buf_re [N];
  logic signed [RN-1:0] buf_im [N];
  logic signed [TW-1:0] tw_re  [N/2];
  logic signed [TW-1:0] tw_im  [N/2];

  function automatic logic signed [TW-1:0] twiddle(input int k, input bit im_part);
    real ang;
    real v;
    int  r;
    ang = -2.0 * 3.14159265358979323846 * k / N;
    v   = (2.0 ** FRAC) * (im_part ? $sin(ang) : $cos(ang));
    r   = (v < 0.0) ? -$rtoi(-v + 0.5) : $rtoi(v + 0.5);
    return TW'(r);
  endfunction

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    for (int k = 0; k < AW; k++) r[k] = v[AW-1-k];
    return r;
  endfunction

  for (genvar k = 0; k < N/2; k++) begin : g_rom
    localparam logic signed [TW-1:0] WR = twiddle(k, 1'b0);
    localparam logic signed [TW-1:0] WI = twiddle(k, 1'b1);
    assign tw_re[k] = WR;
    assign tw_im[k] = WI;
  end

  int h_val;
  int lo_val;
  logic [AW-1:0] idx_i;
  logic [AW-1:0] idx_j;
  logic [TA-1:0] tw_idx;
  logic signed [RN-1:0] a_re, a_im, w_re, w_im;
  logic signed [RN-1:0] y0_re, y0_im, y1_re, y1_im;
  logic signed [PW-1:0] br_x, bi_x, wr_x, wi_x, pr, pi;
`ifdef FFT_STAGE_SCALE_EN
  logic signed [RN:0] s0_re, s0_im, s1_re, s1_im;
`endif

  // Butterfly datapath: pair (i, j) and twiddle index for the current (stage, bfly).
  always_comb begin
    h_val  = 1 << stage;
    lo_val = int'(bfly) & (h_val - 1);
    idx_i  = AW'(((int'(bfly) >> stage) << (int'(stage) + 1)) + lo_val);
    idx_j  = AW'(((int'(bfly) >> stage) << (int'(stage) + 1)) + lo_val + h_val);
    tw_idx = TA'(lo_val << (L - 1 - int'(stage)));
    a_re   = buf_re[idx_i];
    a_im   = buf_im[idx_i];
    br_x   = PW'(buf_re[idx_j]);
    bi_x   = PW'(buf_im[idx_j]);
    wr_x   = PW'(tw_re[tw_idx]);
    wi_x   = PW'(tw_im[tw_idx]);
    pr     = br_x * wr_x - bi_x * wi_x;
    pi     = br_x * wi_x + bi_x * wr_x;
    w_re   = RN'(pr >>> FRAC);
    w_im   = RN'(pi >>> FRAC);
`ifdef FFT_STAGE_SCALE_EN
    s0_re  = (RN+1)'(a_re) + (RN+1)'(w_re);
    s0_im  = (RN+1)'(a_im) + (RN+1)'(w_im);
    s1_re  = (RN+1)'(a_re) - (RN+1)'(w_re);
    s1_im  = (RN+1)'(a_im) - (RN+1)'(w_im);
    y0_re  = RN'(s0_re >>> 1);
    y0_im  = RN'(s0_im >>> 1);
    y1_re  = RN'(s1_re >>> 1);
    y1_im  = RN'(s1_im >>> 1);
`else
    y0_re  = a_re + w_re;
    y0_im  = a_im + w_im;
    y1_re  = a_re - w_re;
    y1_im  = a_im - w_im;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_LOAD;
      cnt       <= '0;
      bfly      <= '0;
      stage     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (in_valid && in_ready) begin
            cnt <= cnt + 1'b1;   // wraps to 0 after sample N-1, ready for unload
            if (cnt == AW'(N-1)) begin
              state    <= S_COMPUTE;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          if (bfly == AW'(N/2-1)) begin
            bfly <= '0;
            if (stage == 4'(L-1)) begin
              stage     <= '0;
              state     <= S_UNLOAD;
              out_valid <= 1'b1;
            end else begin
              stage <= stage + 1'b1;
            end
          end else begin
            bfly <= bfly + 1'b1;
          end
        end
        S_UNLOAD: begin
          if (out_ready) begin
            cnt      <= cnt + 1'b1;
            out_last <= (cnt == AW'(N-2));
            if (cnt == AW'(N-1)) begin
              state     <= S_LOAD;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  // Buffer is not reset; a reset cycle only suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_LOAD && in_valid && in_ready) begin
        buf_re[bitrev(cnt)] <= in_re;
        buf_im[bitrev(cnt)] <= in_im;
      end else if (state == S_COMPUTE) begin
        buf_re[idx_i] <= y0_re;
        buf_im[idx_i] <= y0_im;
        buf_re[idx_j] <= y1_re;
        buf_im[idx_j] <= y1_im;
      end
    end
  end

  assign out_re = out_valid ? buf_re[cnt] : '0;
  assign out_im = out_valid ? buf_im[cnt] : '0;

endmodule

// File: tb/tb_fft_iter_stream.sv
// tb_fft_iter_stream: scoreboard bench for fft_iter_stream (N=8, RN=16, FRAC=14).
//   Expected bins come from a floating-point DFT of each driven frame.
module tb_fft_iter_stream;
  localparam int N    = 8;
  localparam int RN   = 16;
  localparam int FRAC = 14;
  localparam int COMP = 3 * N / 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic signed [RN-1:0] in_re = '0;
  logic signed [RN-1:0] in_im = '0;
  logic in_ready, out_valid, out_last, busy;
  logic signed [RN-1:0] out_re, out_im;

  fft_iter_stream #(.N(N), .RN(RN), .FRAC(FRAC)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int re; int im; int tol; bit last;} bin_t;
  bin_t sb[$];

  int n_chk = 0;
  int n_bad = 0;
  int xr[N];
  int xi[N];
  bit rand_ready = 1'b0;

  bit stalled = 1'b0;
  int hold_re, hold_im;
  bin_t e;

  task automatic check(input string tag, input int obs, input int exp_v, input int tol);
    int d;
    n_chk++;
    d = obs - exp_v;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (tol %0d) at %0t", tag, obs, exp_v, tol, $time);
    end
  endtask

  function automatic int rnd(input real v);
    if (v < 0.0) return -$rtoi(-v + 0.5);
    return $rtoi(v + 0.5);
  endfunction

  task automatic push_expected(input int tol);
    real pi_c, sr, si, ang;
    bin_t b;
    pi_c = 3.14159265358979323846;
    for (int k = 0; k < N; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < N; n++) begin
        ang = 2.0 * pi_c * k * n / N;
        sr  = sr + xr[n] * $cos(ang) + xi[n] * $sin(ang);
        si  = si + xi[n] * $cos(ang) - xr[n] * $sin(ang);
      end
`ifdef FFT_STAGE_SCALE_EN
      sr = sr / N;
      si = si / N;
`endif
      b.re = rnd(sr);
      b.im = rnd(si);
      b.tol = tol;
      b.last = (k == N - 1);
      sb.push_back(b);
    end
  endtask

  task automatic send_frame(input bit push, input int tol, input bit hold_valid);
    int guard;
    if (push) push_expected(tol);
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_re = RN'(xr[k]);
      in_im = RN'(xi[k]);
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 1000) begin
        guard++;
        @(negedge clk);
      end
      if (guard >= 1000) check("load_timeout", guard, 0, 0);
      @(posedge clk);
      #1;
    end
    if (!hold_valid) in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 3000) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 3000) check("drain_timeout", sb.size(), 0, 0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: stall stability and scoreboard compare.
  always @(negedge clk) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("hold_valid", int'(out_valid), 1, 0);
        check("hold_re", int'(out_re), hold_re, 0);
        check("hold_im", int'(out_im), hold_im, 0);
      end
      stalled = out_valid && !out_ready;
      hold_re = int'(out_re);
      hold_im = int'(out_im);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_bin", 1, 0, 0);
        end else begin
          e = sb.pop_front();
          check("bin_re", int'(out_re), e.re, e.tol);
          check("bin_im", int'(out_im), e.im, e.tol);
          check("bin_last", int'(out_last), int'(e.last), 0);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  initial begin
    int tol_imp, low, ul, first, acc, cyc, busy_low, guard;
    real pi_c;
    pi_c = 3.14159265358979323846;
`ifdef FFT_STAGE_SCALE_EN
    tol_imp = 1;
`else
    tol_imp = 0;
`endif

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1, 0);
    check("rst_out_valid", int'(out_valid), 0, 0);
    check("rst_busy", int'(busy), 0, 0);
    check("rst_out_last", int'(out_last), 0, 0);
    check("rst_out_re", int'(out_re), 0, 0);
    @(posedge clk);
    #1;

    // impulse
    for (int n = 0; n < N; n++) begin xr[n] = 0; xi[n] = 0; end
    xr[0] = 1000;
    send_frame(1'b1, tol_imp, 1'b0);
    drain();

    // DC
    for (int n = 0; n < N; n++) begin xr[n] = 1000; xi[n] = 0; end
    send_frame(1'b1, 1, 1'b0);
    drain();

    // tone at bin 1
    for (int n = 0; n < N; n++) begin
      xr[n] = rnd(2048.0 * $cos(2.0 * pi_c * n / N));
      xi[n] = rnd(2048.0 * $sin(2.0 * pi_c * n / N));
    end
    send_frame(1'b1, 8, 1'b0);
    drain();

    // DC under random backpressure, in_valid held high through COMPUTE
    for (int n = 0; n < N; n++) begin xr[n] = 1000; xi[n] = 0; end
    rand_ready = 1'b1;
    send_frame(1'b1, 1, 1'b1);
    low = 0; ul = 0; first = -1; acc = 0; cyc = 0; busy_low = 0; guard = 0;
    while (guard < 2000) begin
      guard++;
      @(negedge clk);
      if (in_ready) break;
      if (in_valid) acc++;
      low++;
      if (!busy) busy_low++;
      if (out_valid) begin
        ul++;
        if (first < 0) first = cyc;
        in_valid = 1'b0;
      end
      cyc++;
    end
    in_valid = 1'b0;
    if (guard >= 2000) check("bp_timeout", guard, 0, 0);
    check("bp_first_bin_latency", first, COMP, 0);
    check("bp_in_ready_low", low, COMP + ul, 0);
    check("bp_busy_low", busy_low, 0, 0);
    check("bp_in_valid_while_busy", int'(acc > 0), 1, 0);
    rand_ready = 1'b0;
    drain();

    // reset during COMPUTE cycle 5, then impulse frame
    for (int n = 0; n < N; n++) begin xr[n] = 777; xi[n] = -300; end
    send_frame(1'b0, 0, 1'b0);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", int'(in_ready), 1, 0);
    check("mid_rst_busy", int'(busy), 0, 0);
    check("mid_rst_out_valid", int'(out_valid), 0, 0);
    @(posedge clk);
    #1;
    for (int n = 0; n < N; n++) begin xr[n] = 0; xi[n] = 0; end
    xr[0] = 1000;
    send_frame(1'b1, tol_imp, 1'b0);
    drain();

    check("sb_left", sb.size(), 0, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
